// File: rtl/div_pkg.sv
// div_pkg: shared FSM states and sizing for the multicycle divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  localparam int DIV_W = 32;
  localparam int DIV_ITERS = DIV_W;
  localparam int CNT_W = $clog2(DIV_ITERS);
endpackage

// File: rtl/div_if.sv
// div_if: controller-to-divider handshake and result bus
interface div_if import div_pkg::*; #(parameter int WIDTH = DIV_W) ();
  logic DivCtrl;
  logic [WIDTH-1:0] A, B, Hi, Lo;
  logic DivDone, DivZero, Busy;
  modport master(output DivCtrl, A, B, input Hi, Lo, DivDone, DivZero, Busy);
  modport slave(input DivCtrl, A, B, output Hi, Lo, DivDone, DivZero, Busy);
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on magnitudes
module div_step import div_pkg::*; #(parameter int WIDTH = DIV_W) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_n,
  output logic [WIDTH-1:0] q_n
);
  logic [WIDTH+1:0] rs, trial;
  assign rs = {r, q[WIDTH-1]};
  assign trial = rs - {2'b00, d};
  assign r_n = trial[WIDTH+1] ? rs[WIDTH:0] : trial[WIDTH:0];
  assign q_n = {q[WIDTH-2:0], ~trial[WIDTH+1]};
endmodule

// File: rtl/div_unit.sv
// div_unit: multicycle signed divider with MIPS div quotient/remainder semantics
module div_unit import div_pkg::*; #(parameter int WIDTH = DIV_W) (
  input logic  clock,
  input logic  reset,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] r, r_n;
  logic [WIDTH-1:0] q, q_n, d;
  logic sa, sb, zp, go;
  assign go = bus.DivCtrl && bus.B != '0;
  assign bus.Busy = state != IDLE;
  div_step #(.WIDTH(WIDTH)) step (.r(r), .q(q), .d(d), .r_n(r_n), .q_n(q_n));
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (go ? RUN : IDLE) :
              state == RUN  ? (cnt == CW'(WIDTH - 1) ? FIX : RUN) : IDLE;
  end
  // zp delays the divide-by-zero flags by one cycle, matching the registered start path
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      r <= '0;
      q <= '0;
      d <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      zp <= 1'b0;
      bus.Hi <= '0;
      bus.Lo <= '0;
      bus.DivDone <= 1'b0;
      bus.DivZero <= 1'b0;
    end else begin
      state <= state_n;
      zp <= state == IDLE && bus.DivCtrl && bus.B == '0;
      bus.DivDone <= zp || state == FIX;
      if (zp) bus.DivZero <= 1'b1;
      if (state == IDLE && go) begin
        sa <= bus.A[WIDTH-1];
        sb <= bus.B[WIDTH-1];
        q <= bus.A[WIDTH-1] ? -bus.A : bus.A;
        d <= bus.B[WIDTH-1] ? -bus.B : bus.B;
        r <= '0;
        cnt <= '0;
        bus.DivZero <= 1'b0;
      end
      if (state == RUN) begin
        r <= r_n;
        q <= q_n;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        bus.Lo <= sa ^ sb ? -q : q;
        bus.Hi <= sa ? -r[WIDTH-1:0] : r[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven and randomized checks of div_unit against a plain-arithmetic model
module tb_div_unit;
  logic clock = 1'b0;
  logic reset;
  int vec = 0;
  int errs = 0;
  div_if #(.WIDTH(32)) bus ();
  div_unit dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  typedef struct {
    logic [31:0] a, b, lo, hi;
  } vec_t;
  vec_t tbl[11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi);
    longint x, y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    lo = 32'(x / y);
    hi = 32'(x % y);
  endfunction
  // poke > 0 re-pulses DivCtrl with 9/3 so it is sampled on that cycle of the run
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lo,
                     input logic [31:0] hi, input int poke, input string tag);
    int n, busy;
    bit done;
    @(negedge clock);
    bus.DivCtrl = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clock);
    #1;
    chk({tag, " done_low_at_start"}, 32'(bus.DivDone), 32'd0);
    busy = int'(bus.Busy);
    @(negedge clock);
    bus.DivCtrl = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    n = 0;
    done = 1'b0;
    while (!done && n < 60) begin
      if (poke > 0 && n + 1 == poke) begin
        bus.DivCtrl = 1'b1;
        bus.A = 32'd9;
        bus.B = 32'd3;
      end
      @(posedge clock);
      #1;
      n++;
      if (n == poke) bus.DivCtrl = 1'b0;
      done = bus.DivDone;
      if (!done) busy += int'(bus.Busy);
    end
    chk({tag, " latency"}, 32'(n), 32'd33);
    chk({tag, " Lo"}, bus.Lo, lo);
    chk({tag, " Hi"}, bus.Hi, hi);
    chk({tag, " DivZero"}, 32'(bus.DivZero), 32'd0);
    chk({tag, " busy_cycles"}, 32'(busy), 32'd33);
  endtask
  initial begin
    logic [31:0] ra, rb, rlo, rhi;
    int dones;
    tbl = '{
      '{32'd100,        32'd7,        32'd14,        32'd2},
      '{32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2,  32'hFFFFFFFE},
      '{32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2,  32'd2},
      '{32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE},
      '{32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0},
      '{32'd7,          32'd100,      32'd0,         32'd7},
      '{32'd0,          32'd5,        32'd0,         32'd0},
      '{32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0},
      '{32'h7FFFFFFF,   32'h80000000, 32'd0,         32'h7FFFFFFF},
      '{32'h80000000,   32'd7,        32'hEDB6DB6E,  32'hFFFFFFFE},
      '{32'h80000000,   32'h80000000, 32'd1,         32'd0}
    };
    reset = 1'b1;
    bus.DivCtrl = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset Hi", bus.Hi, 32'd0);
    chk("reset Lo", bus.Lo, 32'd0);
    chk("reset DivDone", 32'(bus.DivDone), 32'd0);
    chk("reset DivZero", 32'(bus.DivZero), 32'd0);
    chk("reset Busy", 32'(bus.Busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 11; i++)
      run(tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, 0, $sformatf("tbl%0d", i));
    run(32'd100, 32'd7, 32'd14, 32'd2, 0, "preload");
    @(negedge clock);
    bus.DivCtrl = 1'b1;
    bus.A = 32'd5;
    bus.B = 32'd0;
    @(posedge clock);
    #1;
    chk("zero edge0 DivDone", 32'(bus.DivDone), 32'd0);
    chk("zero edge0 Busy", 32'(bus.Busy), 32'd0);
    @(negedge clock);
    bus.DivCtrl = 1'b0;
    @(posedge clock);
    #1;
    chk("zero DivZero", 32'(bus.DivZero), 32'd1);
    chk("zero DivDone", 32'(bus.DivDone), 32'd1);
    chk("zero Hi held", bus.Hi, 32'd2);
    chk("zero Lo held", bus.Lo, 32'd14);
    @(posedge clock);
    #1;
    chk("zero DivDone pulse", 32'(bus.DivDone), 32'd0);
    chk("zero DivZero hold", 32'(bus.DivZero), 32'd1);
    chk("zero Busy", 32'(bus.Busy), 32'd0);
    run(32'd50, 32'd8, 32'd6, 32'd2, 0, "after_zero");
    run(32'd100, 32'd7, 32'd14, 32'd2, 5, "ignore_restart");
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
      if ($urandom_range(0, 1) == 1) rb = -rb;
      if (rb == 32'd0) rb = 32'd3;
      ref_div(ra, rb, rlo, rhi);
      run(ra, rb, rlo, rhi, 0, $sformatf("rnd%0d", i));
    end
    run(32'd100, 32'd7, 32'd14, 32'd2, 0, "pre_abort");
    @(negedge clock);
    bus.DivCtrl = 1'b1;
    bus.A = 32'd100;
    bus.B = 32'd7;
    @(posedge clock);
    @(negedge clock);
    bus.DivCtrl = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("abort Busy", 32'(bus.Busy), 32'd0);
    chk("abort Hi", bus.Hi, 32'd0);
    chk("abort Lo", bus.Lo, 32'd0);
    chk("abort DivDone", 32'(bus.DivDone), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      dones += int'(bus.DivDone);
    end
    chk("abort no DivDone", 32'(dones), 32'd0);
    run(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, "post_abort");
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
